// File: rtl/updown_repeat_ctrl_pkg.sv
// Shared definitions for the up/down setpoint controller.
// Holds the step strobe codes, the FSM state encodings and a sizing helper.
// The sizing helper returns the repeat timer width.
package updown_repeat_ctrl_pkg;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_UP   = 2'b01;
  localparam logic [1:0] SEL_DN   = 2'b10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    UP_CHK   = 3'd1,
    UP_INC   = 3'd2,
    UP_HOLD  = 3'd3,
    DN_CHK   = 3'd4,
    DN_INC   = 3'd5,
    DN_HOLD  = 3'd6,
    WAIT_REL = 3'd7
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Timer width is at least 1 bit, so that HOLD_CYCLES = REPEAT_CYCLES = 1 still
  // gives a legal vector.
  function automatic int unsigned timer_width(input int unsigned hold_c,
                                              input int unsigned rep_c);
    int unsigned w;
    w = $clog2(max_u(hold_c, rep_c));
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/updown_repeat_ctrl_timer.sv
// Loadable down-counter that paces auto-repeat steps.
// Ports:
//   clk, rst  - clock and synchronous active-high reset.
//   ena       - clock enable; the count holds while it is low.
//   load      - load load_val on the next enabled edge.
//   load_val  - value to load.
//   zero      - combinational: the count is zero.
// The counter stops at zero. It never wraps.
module repeat_timer #(
  parameter int unsigned CNT_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;

  // Count register: load has priority over the decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (ena) begin
      if (load) begin
        cnt_q <= load_val;
      end else if (cnt_q != '0) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/updown_repeat_ctrl.sv
// Up/down setpoint controller with saturation and press-and-hold auto-repeat.
// Ports:
//   clk, rst      - clock and synchronous active-high reset.
//   ena           - clock enable; while it is low, all state freezes and sel reads 00.
//   xu, xd        - level up/down requests. These are already debounced.
//   y             - registered setpoint.
//   sel           - step strobe: 01 up, 10 down, 00 none.
//   at_max/at_min - combinational limit flags on y.
module updown_repeat_ctrl
  import updown_repeat_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH         = 7,
  parameter int unsigned MIN_VAL       = 0,
  parameter int unsigned MAX_VAL       = 100,
  parameter int unsigned RESET_VAL     = 0,
  parameter int unsigned STEP          = 1,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 10_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             xu,
  input  logic             xd,
  output logic [WIDTH-1:0] y,
  output logic [1:0]       sel,
  output logic             at_max,
  output logic             at_min
);

  localparam int unsigned TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam int unsigned EW = WIDTH + 1;

  if (MIN_VAL > RESET_VAL || RESET_VAL > MAX_VAL ||
      64'(MAX_VAL) >= (64'd1 << WIDTH) || STEP == 0 ||
      HOLD_CYCLES == 0 || REPEAT_CYCLES == 0) begin : g_bad_params
    $error("updown_repeat_ctrl: illegal parameter combination");
  end

  state_e         state_q;
  logic [WIDTH-1:0] y_q;
  logic           first_q;
  logic [1:0]     req;
  logic           timer_load;
  logic [TW-1:0]  timer_val;
  logic           timer_zero;

  // Saturating step values. The extra bit keeps y+STEP from wrapping.
  logic [EW-1:0]    y_ext;
  logic [EW-1:0]    y_up_sum;
  logic [EW-1:0]    y_dn_diff;
  logic [WIDTH-1:0] y_up_d;
  logic [WIDTH-1:0] y_dn_d;

  assign req       = {xd, xu};
  assign y_ext     = {1'b0, y_q};
  assign y_up_sum  = y_ext + EW'(STEP);
  assign y_dn_diff = y_ext - EW'(STEP);
  assign y_up_d    = (y_up_sum > EW'(MAX_VAL)) ? WIDTH'(MAX_VAL) : y_up_sum[WIDTH-1:0];
  assign y_dn_d    = (y_ext < (EW'(MIN_VAL) + EW'(STEP))) ? WIDTH'(MIN_VAL)
                                                          : y_dn_diff[WIDTH-1:0];

  // The timer is reloaded at every step. The first step of a press uses the
  // longer hold delay.
  assign timer_load = (state_q == UP_INC) || (state_q == DN_INC);
  assign timer_val  = first_q ? TW'(HOLD_CYCLES - 1) : TW'(REPEAT_CYCLES - 1);

  repeat_timer #(
    .CNT_W (TW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Control FSM, first-step flag and setpoint register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      y_q     <= WIDTH'(RESET_VAL);
      first_q <= 1'b0;
    end else if (ena) begin
      case (state_q)
        IDLE: begin
          if (req == 2'b01) begin
            state_q <= UP_CHK;
            first_q <= 1'b1;
          end else if (req == 2'b10) begin
            state_q <= DN_CHK;
            first_q <= 1'b1;
          end
        end
        UP_CHK:   state_q <= (y_q == WIDTH'(MAX_VAL)) ? WAIT_REL : UP_INC;
        UP_INC: begin
          y_q     <= y_up_d;
          first_q <= 1'b0;
          state_q <= UP_HOLD;
        end
        UP_HOLD: begin
          if (req != 2'b01)   state_q <= WAIT_REL;
          else if (timer_zero) state_q <= UP_CHK;
        end
        DN_CHK:   state_q <= (y_q == WIDTH'(MIN_VAL)) ? WAIT_REL : DN_INC;
        DN_INC: begin
          y_q     <= y_dn_d;
          first_q <= 1'b0;
          state_q <= DN_HOLD;
        end
        DN_HOLD: begin
          if (req != 2'b10)   state_q <= WAIT_REL;
          else if (timer_zero) state_q <= DN_CHK;
        end
        WAIT_REL: if (req == 2'b00) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // Moore strobe decode. The strobe is masked while the clock enable is low.
  always_comb begin
    sel = SEL_NONE;
    if (ena) begin
      if (state_q == UP_INC)      sel = SEL_UP;
      else if (state_q == DN_INC) sel = SEL_DN;
    end
  end

  assign y      = y_q;
  assign at_max = (y_q == WIDTH'(MAX_VAL));
  assign at_min = (y_q == WIDTH'(MIN_VAL));

endmodule

// File: doc/updown_repeat_ctrl.md
# updown_repeat_ctrl

Parametrised up/down setpoint controller for the PWM signal generator. It turns level-sensitive up/down request inputs (xu, xd) into a saturating setpoint register and one-cycle step strobes. Its step size, limits and width are configurable, and a press held long enough auto-repeats. It sits between the debounced push-button inputs and the PWM comparator, and owns the duty setpoint value rather than only steering an external counter.

## Interface
- WIDTH, 7: setpoint width in bits.
- MIN_VAL, 0: lower saturation limit.
- MAX_VAL, 100: upper saturation limit.
- RESET_VAL, 0: setpoint after reset.
- STEP, 1: increment/decrement per step.
- HOLD_CYCLES, 50_000_000: enabled cycles a press must be held before the first auto-repeat step.
- REPEAT_CYCLES, 10_000_000: enabled hold cycles between later auto-repeat steps.
- clk  in  1  single system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- ena  in  1  clock enable; when low, all state, counters and y hold, and sel is forced to 00.
- xu  in  1  up request, level, already debounced/synchronised.
- xd  in  1  down request, level, already debounced/synchronised.
- y  out  WIDTH  current setpoint, registered.
- sel  out  2  step strobe: 00 none, 01 up step, 10 down step; never 11.
- at_max  out  1  combinational: y == MAX_VAL.
- at_min  out  1  combinational: y == MIN_VAL.

## Operation
- Constraint: MIN_VAL <= RESET_VAL <= MAX_VAL < 2^WIDTH, STEP >= 1, HOLD_CYCLES >= 1, REPEAT_CYCLES >= 1. The implementation checks these at elaboration.
- Request code r = {xd, xu}.
- States and transitions:
  - IDLE, sel=00: r=01 -> UP_CHK; r=10 -> DN_CHK; r=00 or 11 -> IDLE. A simultaneous press does nothing.
  - UP_CHK, sel=00: y==MAX_VAL -> WAIT_REL; else -> UP_INC.
  - UP_INC, sel=01: y <= sat_up(y); -> UP_HOLD. The timer loads HOLD_CYCLES-1 if this is the first step of the press, else REPEAT_CYCLES-1.
  - UP_HOLD, sel=00: r!=01 -> WAIT_REL. Otherwise: timer==0 -> UP_CHK; else decrement the timer.
  - DN_CHK, DN_INC (sel=10) and DN_HOLD mirror the up states, using MIN_VAL, sat_dn and r=10.
  - WAIT_REL, sel=00: r=00 -> IDLE; else stay.
- A first-step flag is set on leaving IDLE and cleared in the first UP_INC/DN_INC.
- Saturation arithmetic uses WIDTH+1-bit intermediates, so there is no wrap-around:
  - sat_up(y) = (y > MAX_VAL-STEP) ? MAX_VAL : y+STEP
  - sat_dn(y) = (y < MIN_VAL+STEP) ? MIN_VAL : y-STEP
- Reaching a limit during auto-repeat: the next CHK goes to WAIT_REL, so no strobe is issued at the limit.
- Direction reversal while held (01 -> 10) goes through WAIT_REL. A full release is required before the opposite direction is accepted.
- sel is Moore, decoded from state, and gated by ena.

## Timing
- Reset values: state IDLE, y=RESET_VAL, sel=00, timer 0, first-step flag clear. Reset mid-press returns to IDLE on the next edge. If the request is still asserted after reset, it is treated as a new press.
- Press seen at edge k (IDLE->CHK):
  - CHK occupies cycle k..k+1.
  - sel strobe occupies cycle k+1..k+2.
  - The new y is visible after edge k+2, i.e. one cycle after the strobe starts.
- Spacing between strobes of one held press, in enabled cycles:
  - first to second: HOLD_CYCLES+2
  - each later pair: REPEAT_CYCLES+2
- ena low freezes everything for the cycle. With ena low, a strobe cycle is stretched in state but sel reads 00; it resumes when ena returns.
- Releasing the request in any HOLD state: WAIT_REL at the next edge, then IDLE one edge after r=00 is seen.

## Structure
- Shared package/header holds:
  - the sel codes SEL_NONE=2'b00, SEL_UP=2'b01, SEL_DN=2'b10;
  - the 3-bit state encodings IDLE, UP_CHK, UP_INC, UP_HOLD, DN_CHK, DN_INC, DN_HOLD, WAIT_REL.
- One sub-module, repeat_timer: a loadable down-counter sized $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)). Ports: clk, rst, ena, load, load_val, zero.
- The FSM, the first-step flag, saturation and the y register live in updown_repeat_ctrl.

## Test plan
- Reset, then WIDTH=7, STEP=1, xu pulse of 3 cycles: y 0 -> 1. Exactly one sel=01 cycle, two cycles after xu is sampled; then back to IDLE.
- y=98, STEP=5, xu held: first strobe gives y=100 (saturated). The next CHK goes to WAIT_REL with no further strobe; at_max=1.
- HOLD_CYCLES=4, REPEAT_CYCLES=2, xd held from y=10: strobes at relative cycles 0, 6, 10, 14. y goes 9, 8, 7, 6.
- xu=xd=1 from IDLE for 20 cycles: sel stays 00 and y is unchanged. xu held then xd added: WAIT_REL, and no down step until both are released.
- ena low for 5 cycles during UP_HOLD: timer and y frozen, sel=00. The repeat strobe is delayed by exactly 5 cycles.
- rst asserted in UP_INC with y=50: the next cycle has y=RESET_VAL, sel=00 and state IDLE.
